// File: rtl/rv32i_hazard_unit.sv
// RV32I hazard unit: shadow copy of in-flight destination registers, operand
// forwarding into ID, load-use stall detection and ID/EX bubble generation.
module rv32i_hazard_unit #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned NUM_STAGES       = 3,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       id_valid_i,
  input  logic [4:0]                 id_rs1_reg_i,
  input  logic [4:0]                 id_rs2_reg_i,
  input  logic                       id_rs1_used_i,
  input  logic                       id_rs2_used_i,
  input  logic                       id_wb_en_i,
  input  logic [4:0]                 id_wb_reg_i,
  input  logic                       id_is_load_i,
  input  logic [XLEN-1:0]            rs1_data_i,
  input  logic [XLEN-1:0]            rs2_data_i,
  input  logic [NUM_STAGES*XLEN-1:0] stage_data_i,
  input  logic                       flush_i,
  output logic [XLEN-1:0]            rs1_fwd_data_o,
  output logic [XLEN-1:0]            rs2_fwd_data_o,
  output logic                       stall_o,
  output logic                       bubble_o,
  output logic [CNT_W-1:0]           stall_count_o,
  output logic [CNT_W-1:0]           fwd_count_o
);

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [NUM_STAGES-1:0] ld_q, ld_d;
  logic [4:0]            rd_q [NUM_STAGES];
  logic [4:0]            rd_d [NUM_STAGES];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  logic [4:0]      src_reg  [2];
  logic            src_used [2];
  logic [XLEN-1:0] src_rf   [2];
  logic [XLEN-1:0] src_out  [2];
  logic [1:0]      hazard;
  logic [1:0]      fwd;
  logic            stall;

  assign src_reg[0]  = id_rs1_reg_i;
  assign src_reg[1]  = id_rs2_reg_i;
  assign src_used[0] = id_rs1_used_i;
  assign src_used[1] = id_rs2_used_i;
  assign src_rf[0]   = rs1_data_i;
  assign src_rf[1]   = rs2_data_i;

  // Scan oldest to youngest so the youngest matching entry is the last to write.
  always_comb begin
    hazard  = '0;
    fwd     = '0;
    src_out = src_rf;
    for (int op = 0; op < 2; op++) begin
      if (!reset_i && src_used[op] && (src_reg[op] != 5'd0)) begin
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
          if (v_q[k] && (rd_q[k] == src_reg[op])) begin
            if (ld_q[k] && (k < int'(LOAD_READY_STAGE))) begin
              hazard[op]  = 1'b1;
              fwd[op]     = 1'b0;
              src_out[op] = src_rf[op];
            end else begin
              hazard[op]  = 1'b0;
              fwd[op]     = 1'b1;
              src_out[op] = stage_data_i[k*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  assign stall          = !reset_i && id_valid_i && !flush_i && (|hazard);
  assign stall_o        = stall;
  assign bubble_o       = !reset_i && (stall || flush_i);
  assign rs1_fwd_data_o = src_out[0];
  assign rs2_fwd_data_o = src_out[1];

  always_comb begin
    v_d  = v_q;
    ld_d = ld_q;
    rd_d = rd_q;
    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      v_d[k]  = v_q[k-1];
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
    v_d[0]  = id_valid_i && id_wb_en_i && (id_wb_reg_i != 5'd0) && !stall && !flush_i;
    ld_d[0] = id_is_load_i;
    rd_d[0] = id_wb_reg_i;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (id_valid_i && !stall && !flush_i && (|fwd) && !(&fwd_cnt_q)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      v_q         <= v_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
    ld_q <= ld_d;
    rd_q <= rd_d;
  end

  assign stall_count_o = stall_cnt_q;
  assign fwd_count_o   = fwd_cnt_q;

endmodule
